// File: rtl/calc_seq_if.sv
// Operand, button and result bundle between the calculator panel and calc_seq.
// The panel side drives operands/buttons; the core drives result and status.
interface calc_seq_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               b_lig;
  logic               b_soma;
  logic               b_sub;
  logic               b_multi;
  logic               b_div;
  logic [2*WIDTH-1:0] Y;
  logic               sinal;
  logic               EN;
  logic               busy;
  logic               done;
  logic               erro;

  modport master (
    output A, B, b_lig, b_soma, b_sub, b_multi, b_div,
    input  Y, sinal, EN, busy, done, erro
  );

  modport slave (
    input  A, B, b_lig, b_soma, b_sub, b_multi, b_div,
    output Y, sinal, EN, busy, done, erro
  );
endinterface

// File: rtl/calc_seq.sv
// WIDTH-generic sequential calculator core: single-cycle add/sub, iterative
// shift-add multiply and restoring divide, with internal button edge detection.
module calc_seq #(
  parameter int WIDTH = 7
) (
  input logic       clk,
  input logic       rst,
  calc_seq_if.slave bus
);
  localparam int YW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_OFF, S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  function automatic logic [YW-1:0] add_res(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
  endfunction

  // MSB of the return value is the sign, the rest is the magnitude.
  function automatic logic [WIDTH:0] sub_res(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    if (a >= b) return {1'b0, a - b};
    else        return {1'b1, b - a};
  endfunction

  state_t           state;
  op_t              op;
  logic [CW-1:0]    cnt;
  logic [4:0]       btn, prev, rise;
  logic             accept;

  logic [WIDTH-1:0] a_r, b_r;
  logic [YW-1:0]    prod, mcand, prod_nx;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem, quo, dvd, rem_nx, quo_nx;
  logic [WIDTH:0]   trial, diff, sub_v;
  logic             ge;

  logic [YW-1:0]    y_r;
  logic             sinal_r, en_r, busy_r, done_r, erro_r;

  assign btn    = {bus.b_div, bus.b_multi, bus.b_sub, bus.b_soma, bus.b_lig};
  assign rise   = btn & ~prev;
  // Power toggle wins over an op press arriving on the same edge.
  assign accept = (state == S_IDLE) && !rise[0] && (|rise[4:1]);

  assign bus.Y     = y_r;
  assign bus.sinal = sinal_r;
  assign bus.EN    = en_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.erro  = erro_r;

  always_comb begin
    prod_nx = prod + (mplier[0] ? mcand : '0);
    trial   = {rem, dvd[WIDTH-1]};
    diff    = trial - {1'b0, b_r};
    ge      = (trial >= {1'b0, b_r});
    rem_nx  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], ge};
    sub_v   = sub_res(a_r, b_r);
  end

  // Iteration datapath: loaded on accept, stepped once per RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r    <= bus.A;
      b_r    <= bus.B;
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.A};
      mplier <= bus.B;
      rem    <= '0;
      quo    <= '0;
      dvd    <= bus.A;
    end else if (state == S_RUN) begin
      prod   <= prod_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nx;
      quo    <= quo_nx;
      dvd    <= dvd << 1;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_OFF;
      op      <= OP_ADD;
      cnt     <= '0;
      prev    <= '1;
      y_r     <= '0;
      sinal_r <= 1'b0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      erro_r  <= 1'b0;
    end else begin
      prev   <= btn;
      done_r <= 1'b0;
      case (state)
        S_OFF: begin
          if (rise[0]) begin
            state <= S_IDLE;
            en_r  <= 1'b1;
          end
        end
        default: begin
          if (rise[0]) begin
            state   <= S_OFF;
            en_r    <= 1'b0;
            y_r     <= '0;
            sinal_r <= 1'b0;
            erro_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            case (state)
              S_IDLE: begin
                if (accept) begin
                  state  <= S_RUN;
                  busy_r <= 1'b1;
                  erro_r <= 1'b0;
                  if (rise[1]) begin
                    op  <= OP_ADD;
                    cnt <= CW'(1);
                  end else if (rise[2]) begin
                    op  <= OP_SUB;
                    cnt <= CW'(1);
                  end else if (rise[3]) begin
                    op  <= OP_MUL;
                    cnt <= CW'(WIDTH);
                  end else begin
                    op  <= OP_DIV;
                    cnt <= CW'(WIDTH);
                  end
                end
              end
              S_RUN: begin
                if (cnt == CW'(1)) begin
                  state  <= S_DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  case (op)
                    OP_ADD: begin
                      y_r     <= add_res(a_r, b_r);
                      sinal_r <= 1'b0;
                    end
                    OP_SUB: begin
                      y_r     <= {{WIDTH{1'b0}}, sub_v[WIDTH-1:0]};
                      sinal_r <= sub_v[WIDTH];
                    end
                    OP_MUL: begin
                      y_r     <= prod_nx;
                      sinal_r <= 1'b0;
                    end
                    default: begin
                      sinal_r <= 1'b0;
                      if (b_r == '0) begin
                        y_r    <= '0;
                        erro_r <= 1'b1;
                      end else begin
                        y_r    <= {rem_nx, quo_nx};
                      end
                    end
                  endcase
                end else begin
                  cnt <= cnt - CW'(1);
                end
              end
              S_DONE: state <= S_IDLE;
              default: state <= S_OFF;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq at WIDTH=7: expected results are queued when
// an operation is launched and compared whenever the core pulses done.
module tb_calc_seq;
  localparam int W = 7;

  typedef struct packed {
    logic [2*W-1:0] y;
    logic           s;
    logic           e;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [2*W-1:0] last_y;

  calc_seq_if #(.WIDTH(W)) bus();
  calc_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // op: 0 add, 1 sub, 2 multiply, 3 divide
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t r;
    r.s = 1'b0;
    r.e = 1'b0;
    r.y = '0;
    case (op)
      0: r.y = (2*W)'(a + b);
      1: if (a >= b) r.y = (2*W)'(a - b);
         else begin r.y = (2*W)'(b - a); r.s = 1'b1; end
      2: r.y = (2*W)'(a * b);
      default:
         if (b == 0) r.e = 1'b1;
         else r.y = (2*W)'(((a % b) << W) | (a / b));
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", bus.done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("result_y", bus.Y, e.y);
        check_val("result_sinal", bus.sinal, e.s);
        check_val("result_erro", bus.erro, e.e);
      end
    end
  end

  // mask bits: 0 soma, 1 sub, 2 multi, 3 div; op is the operation that should win.
  task automatic do_op(input logic [3:0] mask, input int op, input int a, input int b,
                       input bit disturb);
    exp_t e;
    int   n;
    int   lat;
    e = model(op, a, b);
    bus.A = W'(a);
    bus.B = W'(b);
    sb.push_back(e);
    {bus.b_div, bus.b_multi, bus.b_sub, bus.b_soma} = mask;
    tick();
    {bus.b_div, bus.b_multi, bus.b_sub, bus.b_soma} = 4'b0000;
    check_val("busy_accept", bus.busy, 1);
    check_val("erro_clear", bus.erro, 0);
    check_val("done_accept", bus.done, 0);
    lat = (op < 2) ? 1 : W;
    n = 0;
    while (n < 40) begin
      if (disturb && n == 1) bus.A = ~W'(a);
      if (disturb && n == 2) bus.b_soma = 1'b1;
      if (disturb && n == 3) bus.b_soma = 1'b0;
      tick();
      n++;
      if (bus.done === 1'b1) break;
      check_val("busy_run", bus.busy, 1);
      check_val("y_hold", bus.Y, last_y);
    end
    check_val("latency", n, lat);
    check_val("busy_done", bus.busy, 0);
    last_y = e.y;
    tick();
    check_val("done_pulse", bus.done, 0);
    check_val("idle_busy", bus.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_y"}, bus.Y, 0);
    check_val({tag, "_sinal"}, bus.sinal, 0);
    check_val({tag, "_en"}, bus.EN, 0);
    check_val({tag, "_busy"}, bus.busy, 0);
    check_val({tag, "_done"}, bus.done, 0);
    check_val({tag, "_erro"}, bus.erro, 0);
  endtask

  task automatic power_press();
    bus.b_lig = 1'b1;
    tick();
    bus.b_lig = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.b_lig = 1'b0;
    bus.b_soma = 1'b1;
    bus.b_sub = 1'b0;
    bus.b_multi = 1'b0;
    bus.b_div = 1'b0;
    last_y = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Power on with soma still held from reset: no operation may start.
    power_press();
    check_val("power_on_en", bus.EN, 1);
    repeat (3) tick();
    check_val("held_soma_busy", bus.busy, 0);
    check_val("held_soma_done", bus.done, 0);
    bus.b_soma = 1'b0;
    tick();

    do_op(4'b0001, 0, 127, 127, 1'b0);
    do_op(4'b0010, 1, 5, 9, 1'b0);
    do_op(4'b0010, 1, 9, 9, 1'b0);
    do_op(4'b0100, 2, 127, 127, 1'b1);
    do_op(4'b1000, 3, 100, 7, 1'b0);
    do_op(4'b1000, 3, 50, 0, 1'b0);
    repeat (2) tick();
    check_val("erro_held", bus.erro, 1);
    check_val("erro_y_zero", bus.Y, 0);
    do_op(4'b0001, 0, 1, 2, 1'b0);

    // Abort a multiply at its third RUN edge.
    bus.A = 7'd127;
    bus.B = 7'd127;
    bus.b_multi = 1'b1;
    tick();
    bus.b_multi = 1'b0;
    repeat (2) tick();
    power_press();
    check_val("abort_en", bus.EN, 0);
    check_val("abort_y", bus.Y, 0);
    check_val("abort_busy", bus.busy, 0);
    check_val("abort_erro", bus.erro, 0);
    last_y = '0;
    repeat (10) tick();

    power_press();
    check_val("repower_en", bus.EN, 1);
    do_op(4'b0110, 1, 20, 6, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int op;
      int a;
      int b;
      op = $urandom_range(0, 3);
      a  = (i == 0) ? 0 : $urandom_range(0, 127);
      b  = (i == 1) ? 127 : $urandom_range(0, 127);
      do_op(4'(1 << op), op, a, b, 1'b0);
    end

    // Reset in the middle of a divide.
    bus.A = 7'd100;
    bus.B = 7'd7;
    bus.b_div = 1'b1;
    tick();
    bus.b_div = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrun_reset");
    rst = 1'b0;
    repeat (10) tick();
    check_val("after_reset_en", bus.EN, 0);

    check_val("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
